// File: rtl/controle_ula_pkg.sv
// Shared definitions for the ALU controller and the ALU itself:
// opcodes, FSM state encoding, datapath widths and decode helpers.
package controle_ula_pkg;

    localparam int unsigned NumRegs  = 8;
    localparam int unsigned DataW    = 8;
    localparam int unsigned OperW    = 6;
    localparam int unsigned RegAddrW = 3;

    localparam logic [2:0] OpLoad = 3'b000;
    localparam logic [2:0] OpAdd  = 3'b001;
    localparam logic [2:0] OpAddi = 3'b010;
    localparam logic [2:0] OpSub  = 3'b011;
    localparam logic [2:0] OpSubi = 3'b100;
    localparam logic [2:0] OpMul  = 3'b101;
    localparam logic [2:0] OpClr  = 3'b110;
    localparam logic [2:0] OpNop  = 3'b111;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRead = 2'd1;
    localparam logic [1:0] StExec = 2'd2;
    localparam logic [1:0] StWb   = 2'd3;

    typedef struct packed {
        logic [2:0]          op;
        logic [RegAddrW-1:0] rd;
        logic [RegAddrW-1:0] rs1;
        logic [OperW-1:0]    src2;
    } instr_t;

    function automatic logic uses_alu(input logic [2:0] op);
        return (op == OpAdd) || (op == OpAddi) || (op == OpSub) ||
               (op == OpSubi) || (op == OpMul);
    endfunction

    // Register-register forms take operand B from rs2 = src2[2:0].
    function automatic logic uses_rs2(input logic [2:0] op);
        return (op == OpAdd) || (op == OpSub) || (op == OpMul);
    endfunction

endpackage

// File: rtl/controle_ula_if.sv
// Register-file access bundle between the controller (master) and
// banco_registradores (slave): write port, clear, two read paths, debug read.
interface controle_ula_if;
    import controle_ula_pkg::*;

    logic                we;
    logic [RegAddrW-1:0] waddr;
    logic [DataW-1:0]    wdata;
    logic                clr;
    logic                re;
    logic [RegAddrW-1:0] raddr_a;
    logic [RegAddrW-1:0] raddr_b;
    logic [OperW-1:0]    rdata_a;
    logic [OperW-1:0]    rdata_b;
    logic [RegAddrW-1:0] dbg_sel;
    logic [DataW-1:0]    dbg_data;

    modport master (
        output we, waddr, wdata, clr, re, raddr_a, raddr_b, dbg_sel,
        input  rdata_a, rdata_b, dbg_data
    );

    modport slave (
        input  we, waddr, wdata, clr, re, raddr_a, raddr_b, dbg_sel,
        output rdata_a, rdata_b, dbg_data
    );

endinterface

// File: rtl/banco_registradores.sv
// 8x8 register file: one write port, clear-all, two registered operand
// read paths (low 6 bits) and a combinational debug read.
module banco_registradores
    import controle_ula_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    controle_ula_if.slave rf
);

    logic [DataW-1:0] mem_q [NumRegs];
    logic [DataW-1:0] mem_d [NumRegs];
    logic [OperW-1:0] rdata_a_q, rdata_a_d;
    logic [OperW-1:0] rdata_b_q, rdata_b_d;

    always_comb begin
        mem_d = mem_q;
        if (rf.clr) begin
            for (int i = 0; i < NumRegs; i++) begin
                mem_d[i] = '0;
            end
        end else if (rf.we) begin
            mem_d[rf.waddr] = rf.wdata;
        end
    end

    // Operand paths only update when asked, so they hold across EXEC.
    always_comb begin
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        if (rf.re) begin
            rdata_a_d = mem_q[rf.raddr_a][OperW-1:0];
            rdata_b_d = mem_q[rf.raddr_b][OperW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NumRegs; i++) begin
                mem_q[i] <= '0;
            end
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            mem_q     <= mem_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
        end
    end

    assign rf.rdata_a  = rdata_a_q;
    assign rf.rdata_b  = rdata_b_q;
    assign rf.dbg_data = mem_q[rf.dbg_sel];

endmodule

// File: rtl/controle_ula.sv
// Multi-cycle ALU controller: accepts one instruction in IDLE, then walks
// READ -> EXEC -> WB against an external combinational ALU.
module controle_ula
    import controle_ula_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [14:0]      instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic [OperW-1:0] alu_a,
    output logic [OperW-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [DataW-1:0] alu_res,
    output logic [DataW-1:0] result,
    output logic             done,
    input  logic [2:0]       dbg_sel,
    output logic [DataW-1:0] dbg_data
);

    logic [1:0]       state_q, state_d;
    instr_t           instr_q, instr_d;
    logic [DataW-1:0] wb_q, wb_d;
    logic [DataW-1:0] result_q, result_d;
    logic             alu_active;

    controle_ula_if rf_bus ();

    banco_registradores u_banco (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rf_bus.slave)
    );

    assign rf_bus.raddr_a = instr_q.rs1;
    assign rf_bus.raddr_b = instr_q.src2[RegAddrW-1:0];
    assign rf_bus.waddr   = instr_q.rd;
    assign rf_bus.wdata   = wb_q;
    assign rf_bus.dbg_sel = dbg_sel;
    assign dbg_data       = rf_bus.dbg_data;

    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        wb_d          = wb_q;
        result_d      = result_q;
        rf_bus.re     = 1'b0;
        rf_bus.we     = 1'b0;
        rf_bus.clr    = 1'b0;
        case (state_q)
            StIdle: begin
                if (instr_valid) begin
                    instr_d = instr_t'(instr);
                    state_d = StRead;
                end
            end
            StRead: begin
                rf_bus.re = 1'b1;
                state_d   = StExec;
            end
            StExec: begin
                if (instr_q.op == OpLoad) begin
                    wb_d = {2'b00, instr_q.src2};
                end else if (uses_alu(instr_q.op)) begin
                    wb_d = alu_res;
                end else begin
                    wb_d = '0;
                end
                state_d = StWb;
            end
            StWb: begin
                if (instr_q.op == OpClr) begin
                    rf_bus.clr = 1'b1;
                    result_d   = '0;
                end else if (instr_q.op != OpNop) begin
                    rf_bus.we = 1'b1;
                    result_d  = wb_q;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            instr_q  <= '0;
            wb_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            wb_q     <= wb_d;
            result_q <= result_d;
        end
    end

    // ALU inputs stay quiet outside EXEC and for non-ALU opcodes.
    assign alu_active  = (state_q == StExec) && uses_alu(instr_q.op);
    assign alu_a       = alu_active ? rf_bus.rdata_a : '0;
    assign alu_b       = !alu_active          ? '0 :
                         uses_rs2(instr_q.op) ? rf_bus.rdata_b : instr_q.src2;
    assign alu_op      = alu_active ? instr_q.op : 3'b000;
    assign instr_ready = (state_q == StIdle);
    assign done        = (state_q == StWb);
    assign result      = result_q;

endmodule

// File: tb/tb_controle_ula.sv
// Self-checking bench for controle_ula with a behavioural ALU and register model.
module tb_controle_ula;

    localparam logic [2:0] LOAD = 3'd0, ADD = 3'd1, ADDI = 3'd2, SUB = 3'd3;
    localparam logic [2:0] SUBI = 3'd4, MUL = 3'd5, CLR = 3'd6, NOP = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [14:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [5:0]  alu_a, alu_b;
    logic [2:0]  alu_op;
    logic [7:0]  alu_res;
    logic [7:0]  result;
    logic        done;
    logic [2:0]  dbg_sel = '0;
    logic [7:0]  dbg_data;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0] m_regs [8];
    logic [7:0] m_result;

    typedef struct {
        logic [2:0] op;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [5:0] src2;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs [9];

    controle_ula dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_res     (alu_res),
        .result      (result),
        .done        (done),
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    // External combinational ALU.
    always_comb begin
        case (alu_op)
            ADD, ADDI: alu_res = {2'b00, alu_a} + {2'b00, alu_b};
            SUB, SUBI: alu_res = {2'b00, alu_a} - {2'b00, alu_b};
            MUL:       alu_res = {2'b00, alu_a} * {2'b00, alu_b};
            default:   alu_res = 8'h00;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [14:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [5:0] src2);
        return {op, rd, rs1, src2};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_result = 8'h00;
    endtask

    task automatic check_all_regs(input string name);
        for (int i = 0; i < 8; i++) begin
            dbg_sel = 3'(i);
            #1;
            chk(name, dbg_data, m_regs[i]);
        end
    endtask

    // One full transaction with cycle-by-cycle checks; called at a negedge.
    task automatic issue(input logic [14:0] ins);
        int         waitc = 0;
        logic [2:0] op, rd, rs1;
        logic [5:0] src2;
        logic       is_alu, is_rr;
        int         av, bv;
        logic [7:0] wv;
        op = ins[14:12]; rd = ins[11:9]; rs1 = ins[8:6]; src2 = ins[5:0];
        is_alu = (op >= ADD) && (op <= MUL);
        is_rr  = (op == ADD) || (op == SUB) || (op == MUL);
        av = is_alu ? int'(m_regs[rs1] % 64) : 0;
        bv = !is_alu ? 0 : is_rr ? int'(m_regs[src2[2:0]] % 64) : int'(src2);
        while (!instr_ready && waitc < 10) begin
            @(negedge clk);
            waitc++;
        end
        chk("ready_before_issue", instr_ready, 1);
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        instr = 15'($urandom);
        chk("read_ready", instr_ready, 0);
        chk("read_done", done, 0);
        chk("read_alu_op", alu_op, 0);
        @(negedge clk);
        chk("exec_alu_a", alu_a, av);
        chk("exec_alu_b", alu_b, bv);
        chk("exec_alu_op", alu_op, is_alu ? op : 3'd0);
        chk("exec_done", done, 0);
        @(negedge clk);
        chk("wb_done", done, 1);
        chk("wb_alu_op", alu_op, 0);
        case (op)
            LOAD:      wv = {2'b00, src2};
            ADD, ADDI: wv = 8'((av + bv) & 255);
            SUB, SUBI: wv = 8'((av - bv) & 255);
            MUL:       wv = 8'((av * bv) & 255);
            default:   wv = 8'h00;
        endcase
        if (op == CLR) model_clear();
        else if (op != NOP) begin
            m_regs[rd] = wv;
            m_result   = wv;
        end
        @(negedge clk);
        chk("post_done", done, 0);
        chk("post_ready", instr_ready, 1);
        chk("post_result", result, m_result);
        dbg_sel = rd;
        #1;
        chk("post_dbg_rd", dbg_data, m_regs[rd]);
    endtask

    initial begin
        int dones;
        vecs[0] = '{LOAD, 3'd1, 3'd0, 6'd5,  8'h05};
        vecs[1] = '{LOAD, 3'd2, 3'd0, 6'd3,  8'h03};
        vecs[2] = '{SUB,  3'd3, 3'd2, 6'd1,  8'hFE};
        vecs[3] = '{LOAD, 3'd1, 3'd0, 6'd63, 8'h3F};
        vecs[4] = '{MUL,  3'd4, 3'd1, 6'd1,  8'h81};
        vecs[5] = '{ADDI, 3'd5, 3'd5, 6'd1,  8'h01};
        vecs[6] = '{ADDI, 3'd5, 3'd5, 6'd1,  8'h02};
        vecs[7] = '{ADDI, 3'd5, 3'd5, 6'd1,  8'h03};
        vecs[8] = '{ADD,  3'd6, 3'd3, 6'd4,  8'h3F};
        model_clear();

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", instr_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_alu_op", alu_op, 0);
        check_all_regs("rst_dbg");

        for (int i = 0; i < 9; i++) begin
            issue(enc(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].src2));
            chk("vec_result", result, vecs[i].exp);
        end
        dbg_sel = 3'd3;
        #1;
        chk("vec_r3_fe", dbg_data, 8'hFE);

        // Second instruction presented while busy must be dropped.
        dones = 0;
        instr = enc(LOAD, 3'd7, 3'd0, 6'd10);
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr = enc(LOAD, 3'd7, 3'd0, 6'd20);
        if (done) dones++;
        @(negedge clk);
        if (done) dones++;
        @(negedge clk);
        if (done) dones++;
        instr_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done) dones++;
        end
        m_regs[7] = 8'd10;
        m_result  = 8'd10;
        chk("busy_done_count", dones, 1);
        chk("busy_result", result, 8'd10);
        dbg_sel = 3'd7;
        #1;
        chk("busy_r7", dbg_data, 8'd10);

        // Fill every register, then clear them all.
        for (int i = 0; i < 8; i++) issue(enc(LOAD, 3'(i), 3'd0, 6'(i + 11)));
        check_all_regs("fill_dbg");
        issue(enc(CLR, 3'd2, 3'd1, 6'd7));
        chk("clr_result", result, 0);
        check_all_regs("clr_dbg");

        for (int i = 0; i < 40; i++) begin
            issue(enc(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 6'($urandom)));
        end
        check_all_regs("rand_dbg");
        if (m_result == 8'h00) issue(enc(LOAD, 3'd0, 3'd0, 6'd33));

        // Reset during EXEC of LOAD r6,9.
        instr = enc(LOAD, 3'd6, 3'd0, 6'd9);
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_clear();
        chk("mid_rst_done", done, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_alu_a", alu_a, 0);
        dbg_sel = 3'd6;
        #1;
        chk("mid_rst_r6", dbg_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_ready", instr_ready, 1);
        dones = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("mid_rst_no_done", dones, 0);
        check_all_regs("mid_rst_dbg");
        issue(enc(ADDI, 3'd6, 3'd6, 6'd9));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
